// File: rtl/sdram_tg_pkg.sv
// Shared types and constants for the SDRAM burst traffic generator.
// Holds the FSM state encoding, LFSR taps and pattern-mode encodings.
package sdram_tg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        WR_REQ   = 3'd2,
        WR_WAIT  = 3'd3,
        RD_REQ   = 3'd4,
        RD_DRAIN = 3'd5,
        DONE     = 3'd6
    } tg_state_e;

    // Taps for x^16+x^14+x^13+x^11+1 as bits 15,13,12,10 of the current word.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic PAT_INC  = 1'b0;
    localparam logic PAT_LFSR = 1'b1;

endpackage

// File: rtl/sdram_tg_pattern.sv
// Deterministic word generator: incrementing counter or Fibonacci LFSR.
// One instance feeds the write FIFO, a second regenerates the stream for checking.
module sdram_tg_pattern
    import sdram_tg_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    input  logic              mode,
    output logic [DATA_W-1:0] word
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);

    logic [DATA_W-1:0] word_nxt;

    always_comb begin
        if (mode == PAT_LFSR) begin
            word_nxt = {word[DATA_W-2:0], ^(word & TAPS)};
        end else begin
            word_nxt = word + DATA_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            word <= RST_VAL;
        end else if (load) begin
            word <= seed;
        end else if (advance) begin
            word <= word_nxt;
        end
    end

endmodule

// File: rtl/sdram_burst_traffic_gen.sv
// Fill / write-burst / read-burst / compare traffic generator for the SDRAM controller.
// Reports done, pass, timeout and a saturating mismatch count per pass.
module sdram_burst_traffic_gen
    import sdram_tg_pkg::*;
#(
    parameter int                BURST_LEN   = 256,
    parameter int                DATA_W      = 16,
    parameter int                CNT_W       = 10,
    parameter int                FIFO_DEPTH  = 512,
    parameter int                PATTERN     = 0,
    parameter logic [DATA_W-1:0] SEED        = 16'h0001,
    parameter int                TIMEOUT_CYC = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              init_end,
    output logic              wr_fifo_wr_en,
    output logic [DATA_W-1:0] wr_fifo_wr_data,
    input  logic [CNT_W-1:0]  wr_fifo_num,
    output logic              i_write_burst_en,
    output logic              i_read_burst_en,
    input  logic [CNT_W-1:0]  rd_fifo_num,
    output logic              read_valid,
    input  logic [DATA_W-1:0] rd_fifo_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output tg_state_e         state_dbg
);

    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] BURST_N   = CNT_W'(BURST_LEN);
    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic             MODE      = (PATTERN == 1) ? PAT_LFSR : PAT_INC;

    tg_state_e         state, state_nxt;
    logic [CNT_W-1:0]  push_cnt, issued_cnt, cmp_cnt;
    logic [15:0]       wait_cnt;
    logic [15:0]       err_cnt_nxt;
    logic              zero_seen, read_valid_q;
    logic [DATA_W-1:0] wr_word, chk_word;
    logic              stall, gen_load, cmp_en, mismatch;
    logic              last_push, last_cmp, wait_active, timeout_hit;

    assign state_dbg = state;

    sdram_tg_pattern #(.DATA_W(DATA_W), .RST_VAL(SEED)) u_wr_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (gen_load),
        .advance (wr_fifo_wr_en),
        .seed    (SEED),
        .mode    (MODE),
        .word    (wr_word)
    );

    sdram_tg_pattern #(.DATA_W(DATA_W), .RST_VAL(SEED)) u_chk_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (gen_load),
        .advance (cmp_en),
        .seed    (SEED),
        .mode    (MODE),
        .word    (chk_word)
    );

    always_comb begin
        stall       = (wr_fifo_num >= FULL_LVL);
        gen_load    = (state == IDLE) && start && init_end;
        cmp_en      = (state == RD_DRAIN) && read_valid_q;
        mismatch    = cmp_en && (rd_fifo_rd_data != chk_word);
        last_push   = (state == FILL) && !stall && (push_cnt == LAST_IDX);
        last_cmp    = cmp_en && (cmp_cnt == LAST_IDX);
        wait_active = ((state == FILL) && stall) || (state == WR_WAIT) || (state == RD_DRAIN);
        timeout_hit = wait_active && (wait_cnt == WAIT_LAST);
        err_cnt_nxt = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start && init_end) state_nxt = FILL;
            FILL:     if (timeout_hit) state_nxt = DONE;
                      else if (last_push) state_nxt = WR_REQ;
            WR_REQ:   state_nxt = WR_WAIT;
            // Two consecutive empty readings absorb the FIFO count latency.
            WR_WAIT:  if (timeout_hit) state_nxt = DONE;
                      else if ((wr_fifo_num == '0) && zero_seen) state_nxt = RD_REQ;
            RD_REQ:   state_nxt = RD_DRAIN;
            RD_DRAIN: if (timeout_hit || last_cmp) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // wr_fifo_wr_en pushes wr_fifo_wr_data at the next edge; read_valid pops and
    // rd_fifo_rd_data is compared one cycle later. Pops only while words remain.
    always_comb begin
        wr_fifo_wr_en    = 1'b0;
        i_write_burst_en = 1'b0;
        i_read_burst_en  = 1'b0;
        read_valid       = 1'b0;
        done             = 1'b0;
        busy             = (state != IDLE);
        case (state)
            FILL:     wr_fifo_wr_en = !stall;
            WR_REQ:   i_write_burst_en = 1'b1;
            RD_REQ:   i_read_burst_en = 1'b1;
            RD_DRAIN: read_valid = (issued_cnt < BURST_N) &&
                                   ((rd_fifo_num > CNT_W'(1)) ||
                                    ((rd_fifo_num == CNT_W'(1)) && !read_valid_q));
            DONE:     done = 1'b1;
            default:  ;
        endcase
        wr_fifo_wr_data = wr_fifo_wr_en ? wr_word : '0;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            push_cnt     <= '0;
            issued_cnt   <= '0;
            cmp_cnt      <= '0;
            wait_cnt     <= '0;
            zero_seen    <= 1'b0;
            read_valid_q <= 1'b0;
            err_cnt      <= '0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            read_valid_q <= read_valid;
            zero_seen    <= (state == WR_WAIT) && (wr_fifo_num == '0);
            if (state != state_nxt) begin
                wait_cnt <= '0;
            end else if (wait_active) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (state == IDLE) begin
                push_cnt   <= '0;
                issued_cnt <= '0;
                cmp_cnt    <= '0;
            end else begin
                if (wr_fifo_wr_en) push_cnt   <= push_cnt + CNT_W'(1);
                if (read_valid)    issued_cnt <= issued_cnt + CNT_W'(1);
                if (cmp_en)        cmp_cnt    <= cmp_cnt + CNT_W'(1);
            end
            if (gen_load) begin
                err_cnt <= '0;
                pass    <= 1'b0;
                timeout <= 1'b0;
            end else begin
                err_cnt <= err_cnt_nxt;
                if (timeout_hit) timeout <= 1'b1;
                // Verdict lands together with the done pulse.
                if ((state_nxt == DONE) && (state != DONE)) begin
                    pass <= (err_cnt_nxt == 16'd0) && !(timeout || timeout_hit);
                end
            end
        end
    end

endmodule
